// File: rtl/alu_sequencer.sv
// Single-transaction sequencer between a request/response handshake and a fixed-latency ALU.
// Optional macro ALU_SEQ_OPCODE_CHECK_EN rejects invalid opcodes with resp_err instead of issuing them.
module alu_sequencer #(
  parameter int unsigned ALU_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_opcode,
  input  logic [7:0]  req_rd,
  input  logic [7:0]  req_rr,
  output logic [7:0]  alu_opcode,
  output logic [7:0]  alu_data_rd,
  output logic [7:0]  alu_data_rr,
  output logic        alu_ci,
  input  logic [15:0] alu_data_o,
  input  logic        alu_co,
  input  logic        alu_zo,
  input  logic        alu_no,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_data,
  output logic        resp_err,
  output logic        flag_c,
  output logic        flag_z,
  output logic        flag_n
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t     state;
  logic [3:0] lat_cnt;
  logic       accept;

  assign accept = req_valid & req_ready;

`ifdef ALU_SEQ_OPCODE_CHECK_EN
  logic err_q;
  assign resp_err = err_q;

  // Upper nibbles 0x1-0x3 and 0x5-0x7 have no ALU operation behind them.
  function automatic logic opcode_ok(input logic [7:0] op);
    return (op[7:4] == 4'h0) || (op[7:4] == 4'h4) || op[7];
  endfunction
`else
  assign resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      req_ready   <= 1'b1;
      resp_valid  <= 1'b0;
      resp_data   <= 16'h0000;
      alu_opcode  <= 8'h00;
      alu_data_rd <= 8'h00;
      alu_data_rr <= 8'h00;
      alu_ci      <= 1'b0;
      flag_c      <= 1'b0;
      flag_z      <= 1'b0;
      flag_n      <= 1'b0;
      lat_cnt     <= 4'd0;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
      err_q       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
            if (!opcode_ok(req_opcode)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_data  <= 16'h0000;
              err_q      <= 1'b1;
            end else
`endif
            begin
              state       <= ISSUE;
              alu_opcode  <= req_opcode;
              alu_data_rd <= req_rd;
              alu_data_rr <= req_rr;
              // Carry-in taken from the status register so ADDC/SUBC chain.
              alu_ci      <= flag_c;
            end
          end
        end
        ISSUE: begin
          lat_cnt <= 4'(ALU_LAT);
          state   <= WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          // Counter reaches zero on this edge: the ALU result is valid now.
          if (lat_cnt == 4'd1) begin
            resp_data  <= alu_data_o;
            flag_c     <= alu_co;
            flag_z     <= alu_zo;
            flag_n     <= alu_no;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
            err_q      <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: emulates a fixed-latency ALU and checks responses against a flag/ALU model.
module tb_alu_sequencer;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [7:0]  req_opcode, req_rd, req_rr;
  logic [7:0]  alu_opcode, alu_data_rd, alu_data_rr;
  logic        alu_ci;
  logic [15:0] alu_data_o = 16'h0;
  logic        alu_co = 1'b0, alu_zo = 1'b0, alu_no = 1'b0;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_err;
  logic        flag_c, flag_z, flag_n;

  int n_vec = 0;
  int n_err = 0;

  // model state
  logic       mc = 1'b0, mz = 1'b0, mn = 1'b0;
  logic [7:0] m_op = 8'h00, m_rd = 8'h00, m_rr = 8'h00;
  logic       m_ci = 1'b0;

  alu_sequencer #(.ALU_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_rd(req_rd), .req_rr(req_rr),
    .alu_opcode(alu_opcode), .alu_data_rd(alu_data_rd), .alu_data_rr(alu_data_rr), .alu_ci(alu_ci),
    .alu_data_o(alu_data_o), .alu_co(alu_co), .alu_zo(alu_zo), .alu_no(alu_no),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
    .flag_c(flag_c), .flag_z(flag_z), .flag_n(flag_n)
  );

  always #5 clk = ~clk;

  // ALU behaviour: returns {c, z, n, data}
  function automatic logic [18:0] alu_fn(input logic [7:0] op, input logic [7:0] rd,
                                         input logic [7:0] rr, input logic ci);
    logic [8:0]  s;
    logic [15:0] d;
    logic        c, n;
    s = 9'h0;
    if (op == 8'h40) begin
      d = 16'(rd) * 16'(rr);
      c = 1'b0;
      n = d[15];
    end else begin
      if (op[7:4] == 4'h0) begin
        case (op[1:0])
          2'd0:    s = {rd, 1'b0};
          2'd1:    s = {rd[0], 1'b0, rd[7:1]};
          2'd2:    s = {rd, ci};
          default: s = {rd[0], ci, rd[7:1]};
        endcase
      end else begin
        case (op)
          8'hC0:   s = {1'b0, rd} + {1'b0, rr};
          8'hC1:   s = {1'b0, rd} + {1'b0, rr} + 9'(ci);
          8'hC2:   s = {1'b0, rd} - {1'b0, rr};
          8'hC3:   s = {1'b0, rd} - {1'b0, rr} - 9'(ci);
          default: s = {1'b0, rd ^ rr};
        endcase
      end
      d = {8'h00, s[7:0]};
      c = s[8];
      n = s[7];
    end
    return {c, (d == 16'h0), n, d};
  endfunction

  // ALU emulation: the true result is present only in the cycle T+1+LAT after acceptance in cycle T.
  int cyc = 0;
  int acc_cyc = -100;
  always @(posedge clk) begin
    if (req_valid && req_ready && !rst) acc_cyc <= cyc;
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (cyc == acc_cyc + 1 + LAT)
      {alu_co, alu_zo, alu_no, alu_data_o} <= alu_fn(alu_opcode, alu_data_rd, alu_data_rr, alu_ci);
    else
      {alu_co, alu_zo, alu_no, alu_data_o} <= 19'($urandom);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [7:0] op, input logic [7:0] rd, input logic [7:0] rr,
                       input int bp, output logic [15:0] got);
    logic [18:0] r;
    logic        inv;
    int          n;
    inv = 1'b0;
`ifdef ALU_SEQ_OPCODE_CHECK_EN
    inv = !((op[7:4] == 4'h0) || (op[7:4] == 4'h4) || op[7]);
`endif
    n = 0;
    while (!req_ready && n < 64) begin @(negedge clk); n++; end
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_opcode = op; req_rd = rd; req_rr = rr; resp_ready = 1'b0;
    @(negedge clk);
    req_valid = 1'b0; req_opcode = 8'($urandom); req_rd = 8'($urandom); req_rr = 8'($urandom);
    if (!inv) begin
      m_op = op; m_rd = rd; m_rr = rr; m_ci = mc;
      r = alu_fn(op, rd, rr, mc);
      chk("issue_opcode", 32'(alu_opcode), 32'(m_op));
      chk("issue_rd", 32'(alu_data_rd), 32'(m_rd));
      chk("issue_rr", 32'(alu_data_rr), 32'(m_rr));
      chk("issue_ci", 32'(alu_ci), 32'(m_ci));
      chk("busy_ready", 32'(req_ready), 32'd0);
    end else begin
      r = {mc, mz, mn, 16'h0000};
    end
    n = 1;
    while (!resp_valid && n < 64) begin @(negedge clk); n++; end
    chk("resp_latency", 32'(n), inv ? 32'd1 : 32'(LAT + 2));
    chk("resp_data", 32'(resp_data), 32'(r[15:0]));
    chk("resp_err", 32'(resp_err), 32'(inv));
    chk("flags", 32'({flag_c, flag_z, flag_n}), 32'(r[18:16]));
    chk("alu_held", 32'({alu_opcode, alu_data_rd, alu_data_rr, alu_ci}), 32'({m_op, m_rd, m_rr, m_ci}));
    {mc, mz, mn} = r[18:16];
    got = resp_data;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", 32'(resp_data), 32'(r[15:0]));
      chk("bp_alu", 32'({alu_opcode, alu_data_rd, alu_data_rr}), 32'({m_op, m_rd, m_rr}));
      chk("bp_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("post_hs_valid", 32'(resp_valid), 32'd0);
    chk("post_hs_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [15:0] got;
    logic [7:0]  rop;
    rst = 1'b1; req_valid = 1'b0; req_opcode = 8'h00; req_rd = 8'h00; req_rr = 8'h00;
    resp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    chk("rst_data", 32'(resp_data), 32'd0);
    chk("rst_alu", 32'({alu_opcode, alu_data_rd, alu_data_rr, alu_ci}), 32'd0);
    chk("rst_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    do_op(8'hC0, 8'd35, 8'd84, 0, got);
    chk("add_const", 32'({got, flag_c, flag_z, flag_n}), 32'({16'h0077, 3'b000}));
    do_op(8'hC2, 8'd35, 8'd84, 0, got);
    chk("sub_const", 32'({got, flag_c, flag_n}), 32'({16'h00CF, 2'b11}));
    do_op(8'hC1, 8'd1, 8'd1, 0, got);
    chk("addc_const", 32'({got, alu_ci}), 32'({16'h0003, 1'b1}));
    do_op(8'h40, 8'd45, 8'd84, 0, got);
    chk("mult_const", 32'({got, flag_n}), 32'({16'h0EC4, 1'b0}));
    do_op(8'hC2, 8'd35, 8'd35, 0, got);
    chk("sub_zero_const", 32'({got, flag_z}), 32'({16'h0000, 1'b1}));
    do_op(8'hC0, 8'd200, 8'd100, 5, got);
    do_op(8'h20, 8'd7, 8'd9, 0, got);

    // Abort in WAIT: no response and flags cleared.
    req_valid = 1'b1; req_opcode = 8'hC2; req_rd = 8'd1; req_rr = 8'd2;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mc = 1'b0; mz = 1'b0; mn = 1'b0; m_op = 8'h00; m_rd = 8'h00; m_rr = 8'h00; m_ci = 1'b0;
    chk("abort_ready", 32'(req_ready), 32'd1);
    chk("abort_flags", 32'({flag_c, flag_z, flag_n}), 32'd0);
    for (int i = 0; i < LAT + 3; i++) begin
      chk("abort_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    do_op(8'hC0, 8'd35, 8'd84, 0, got);
    chk("add_after_abort", 32'(got), 32'h0077);

    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 5))
        0:       rop = 8'hC0;
        1:       rop = 8'hC1;
        2:       rop = 8'hC2;
        3:       rop = 8'hC3;
        4:       rop = 8'h40;
        default: rop = 8'($urandom);
      endcase
      do_op(rop, 8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), got);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL take parameter ALU_LAT, default 2, meaning cycles from ALU input drive to valid ALU output (legal 1..15).
REQ-002 The block SHALL have one clock `clk`; reset is synchronous and active-high (`rst`).
REQ-003 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  sync active-high reset
- req_valid  in  1  request present
- req_ready  out  1  sequencer can accept
- req_opcode  in  8  ALU opcode
- req_rd  in  8  operand Rd
- req_rr  in  8  operand Rr
- alu_opcode  out  8  to ALU opcode
- alu_data_rd  out  8  to ALU data_rd
- alu_data_rr  out  8  to ALU data_rr
- alu_ci  out  1  to ALU ci
- alu_data_o  in  16  from ALU result
- alu_co / alu_zo / alu_no  in  1 each  from ALU flags
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts
- resp_data  out  16  captured result
- resp_err  out  1  request rejected (see REQ-019)
- flag_c / flag_z / flag_n  out  1 each  status register

Function
REQ-004 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-005 req_ready SHALL be 1 only in IDLE; acceptance SHALL be req_valid & req_ready.
REQ-006 On acceptance in cycle T, the block SHALL register opcode/rd/rr onto alu_* outputs and SHALL drive alu_ci from flag_c, all valid from T+1 (ISSUE).
REQ-007 alu_* outputs SHALL hold stable from ISSUE until the response handshake completes.
REQ-008 A 4-bit latency counter SHALL load ALU_LAT in ISSUE and decrement in WAIT; alu_data_o and flags SHALL be sampled in the cycle the counter reaches 0, at T+1+ALU_LAT.
REQ-009 On sampling, the block SHALL update resp_data, flag_c, flag_z and flag_n from alu_data_o, alu_co, alu_zo and alu_no, then enter RESP with resp_valid=1 next cycle.
REQ-010 resp_valid and resp_data SHALL hold until resp_valid & resp_ready; the block SHALL then return to IDLE in the next cycle.
REQ-011 Minimum request-to-request spacing SHALL be ALU_LAT+3 cycles; no overlap of request and response handshakes is possible.
REQ-012 Back-to-back ADDC/SUBC SHALL see the flag_c written by the preceding operation (carry chaining).
REQ-013 Status flags SHALL change only at sampling (REQ-009) or reset; they SHALL be unaffected by rejected requests.
REQ-014 resp_valid held low by rst SHALL not be deasserted by any other means than a handshake.
REQ-015 Opcode decode for validity: upper nibble 0000 (shifts, low 2 bits select), 0100 MULT, 1000-1111 logic/arith; nibbles 0001-0011 and 0101-0111 are invalid.

Reset
REQ-016 On rst, the block SHALL force state=IDLE, req_ready=1 (in the following cycle), resp_valid=0, resp_err=0, resp_data=0, alu_opcode=0, alu_data_rd=0, alu_data_rr=0, alu_ci=0, flags=0 and counter=0.
REQ-017 rst asserted in ISSUE, WAIT or RESP SHALL abort the operation with no response and no flag update.
REQ-018 rst SHALL take priority over every handshake in the same cycle.

Configuration
REQ-019 With ALU_SEQ_OPCODE_CHECK_EN defined, an accepted invalid opcode (REQ-015) SHALL skip ISSUE/WAIT, go directly to RESP next cycle with resp_err=1 and resp_data=0, and leave alu_* outputs and flags unchanged.
REQ-020 Without ALU_SEQ_OPCODE_CHECK_EN, all opcodes SHALL be issued to the ALU, and resp_err SHALL be tied to 0.

Verification
REQ-021 ADD: opcode 0xC0, rd=35, rr=84 -> resp_data=0x0077, c=0, z=0, n=0; resp_valid rises at T+ALU_LAT+2.
REQ-022 SUB then ADDC: SUB 35-84 -> 0x00CF, c=1, n=1; then ADDC 1+1 -> alu_ci=1 observed, resp_data=0x0003.
REQ-023 MULT: 0x40, 45*84 -> 0x0EC4, n=0; SUB 35-35 -> 0x0000, z=1.
REQ-024 Backpressure: resp_ready low for 5 cycles -> resp_valid, resp_data and alu_* outputs stable, req_ready=0 throughout; req_ready=1 one cycle after the handshake.
REQ-025 Reset in WAIT -> no resp_valid, flags=0, req_ready=1 the next cycle; a subsequent ADD completes correctly.
REQ-026 With macro defined, opcode 0x20 -> resp_err=1 one cycle after acceptance, resp_data=0, flags unchanged, alu_opcode unchanged; without the macro, the same opcode is issued to the ALU.
